// File: rtl/convertidor_n_a_8_pkg.sv
// Shared definitions for the word-to-byte serialiser: width-select
// encodings, FSM state type and the active-byte helper.
package convertidor_pkg;

    // PCLK width-select encodings (used only when MODO = 0)
    localparam logic [1:0] ANCHO_32  = 2'b00;
    localparam logic [1:0] ANCHO_16  = 2'b01;
    localparam logic [1:0] ANCHO_8   = 2'b10;
    localparam logic [1:0] ANCHO_INV = 2'b11;

    // IDLE: no word held; SEND: a word is being streamed out byte by byte
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } estado_t;

    // Number of active bytes for a given select; 0 flags an unusable select
    // (the reserved encoding, or a shift that leaves no bytes at all).
    function automatic int bytes_activos(input logic       modo,
                                         input logic [1:0] pclk,
                                         input int         nbytes);
        int result;
        result = 0;
        if (modo) begin
            result = nbytes;
        end else if (pclk != ANCHO_INV) begin
            result = nbytes >> pclk;
        end
        return result;
    endfunction

endpackage

// File: rtl/convertidor_n_a_8_if.sv
// Handshake bundle between the PIPE-side word source (master) and the
// serialiser (slave): word input channel, byte output channel, status.
interface convertidor_n_a_8_if #(
    parameter int IN_W = 32
);
    logic            MODO;
    logic [1:0]      PCLK;
    logic [IN_W-1:0] in;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      out_8;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            err_modo;

    modport master (
        output MODO, PCLK, in, in_valid, out_ready,
        input  in_ready, out_8, out_valid, out_last, err_modo
    );

    modport slave (
        input  MODO, PCLK, in, in_valid, out_ready,
        output in_ready, out_8, out_valid, out_last, err_modo
    );
endinterface

// File: rtl/convertidor_n_a_8.sv
// Parametrised word-to-byte serialiser. Accepts one IN_W-bit word per
// handshake and streams its active bytes MSB-first on an 8-bit
// valid/ready channel, reloading on the last byte so back-to-back words
// flow without bubbles.
module convertidor_n_a_8
    import convertidor_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    convertidor_n_a_8_if.slave   bus
);

    localparam int NBYTES = IN_W / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    estado_t         state_q;
    logic [CW-1:0]   cnt_q;
    logic [IN_W-1:0] word_q;
    logic [7:0]      out8_q;
    logic            last_q;
    logic            err_q;

    int              act_d;
    logic            accept_d;
    logic [CW-1:0]   first_idx_d;
    logic [CW-1:0]   next_idx_d;

    // A new word may enter when nothing is held, or when the last byte of
    // the current word leaves in this very cycle.
    assign bus.in_ready  = (state_q == IDLE) || (last_q && (state_q == SEND) && bus.out_ready);
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_8     = out8_q;
    assign bus.out_last  = last_q;
    assign bus.err_modo  = err_q;

    // Decode the incoming width select and the byte indices for the next edge
    always_comb begin
        act_d       = bytes_activos(bus.MODO, bus.PCLK, NBYTES);
        accept_d    = bus.in_valid && bus.in_ready;
        first_idx_d = '0;
        if (act_d != 0) begin
            first_idx_d = CW'(act_d - 1);
        end
        next_idx_d  = cnt_q - 1'b1;
    end

    // Serialiser FSM: captures words, walks the byte counter down, flags bad selects
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            out8_q  <= 8'h00;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept_d) begin
                if (act_d == 0) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    out8_q  <= 8'h00;
                    last_q  <= 1'b0;
                    err_q   <= 1'b1;
                end else begin
                    state_q <= SEND;
                    word_q  <= bus.in;
                    cnt_q   <= first_idx_d;
                    out8_q  <= bus.in[{first_idx_d, 3'b000} +: 8];
                    last_q  <= (act_d == 1);
                end
            end else if ((state_q == SEND) && bus.out_ready) begin
                if (cnt_q != '0) begin
                    cnt_q  <= next_idx_d;
                    out8_q <= word_q[{next_idx_d, 3'b000} +: 8];
                    last_q <= (next_idx_d == '0);
                end else begin
                    state_q <= IDLE;
                    out8_q  <= 8'h00;
                    last_q  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/convertidor_n_a_8.md
# convertidor_n_a_8

Parametrised word-to-byte serialiser for the PHY transmit path. It accepts one IN_W-bit parallel word per handshake and emits its active bytes, most-significant active byte first, on an 8-bit stream with valid/ready flow control. The active width comes from the PCLK width-select, or is forced to full width by MODO. It sits between the PIPE-side parallel data and the byte-wide encoder, and supersedes the fixed 32-bit converter.

## Interface
- IN_W, default 32: input word width; must be 8·2^k with k ≥ 0. NBYTES = IN_W/8.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- MODO  in  1  1 forces full width (NBYTES active), ignoring PCLK.
- PCLK  in  2  width select, used when MODO=0: active bytes = NBYTES >> PCLK. PCLK=2'b11, or a result of 0, is invalid.
- in  in  IN_W  parallel word. Active bytes are the low ones: bytes [act-1:0].
- in_valid  in  1  word present.
- in_ready  out  1  word accepted when in_valid && in_ready.
- out_8  out  8  byte output.
- out_valid  out  1  out_8 holds a valid byte.
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
- out_last  out  1  qualifies the final byte of the current word.
- err_modo  out  1  one-cycle pulse when a word is accepted with an invalid width select.

## Operation
- States:
  - IDLE: no word held.
  - SEND: a word is held; cnt counts the remaining bytes minus 1; cnt is clog2(NBYTES) bits wide, minimum 1.
- MODO, PCLK and in are captured into registers on accept. Changing them mid-word has no effect on the word in flight.
- IDLE, accept with a valid select:
  - Load the word register and set cnt = act-1.
  - Drive out_8 = byte[act-1] of the captured word.
  - Go to SEND.
- IDLE, accept with an invalid select:
  - Discard the word.
  - Pulse err_modo.
  - Stay in IDLE.
- SEND, byte handshake with cnt > 0:
  - Decrement cnt.
  - out_8 = byte[cnt-1].
- SEND, byte handshake with cnt == 0 (the last byte):
  - If in_valid is also high, accept the new word in the same cycle and apply the IDLE-accept rules. A new word with a valid select stays in SEND with no bubble.
  - Otherwise, go to IDLE.
- out_last = (state==SEND && cnt==0).
- out_valid = (state==SEND).
- in_ready = (state==IDLE) || (out_valid && out_last && out_ready). This is combinational from out_ready.
- Backpressure: while out_valid && !out_ready, out_8, out_last and cnt hold stable.
- Byte order is big-endian within the active window. Example: 32-bit word 0xA1B2C3D4 in 16-bit mode emits C3, then D4.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - out_8 = 8'h00, out_valid = 0, out_last = 0, err_modo = 0.
  - in_ready = 1 on the cycle after reset deasserts.
- Latency: a word accepted at edge N gives its first byte valid after edge N (cycle N+1).
- Throughput: with out_ready held high, a word with `act` active bytes occupies exactly `act` cycles. Consecutive words produce no idle cycles.
- err_modo is high for exactly the one cycle following the accepting edge. An invalid word produces no out_valid.
- Reset asserted mid-word: the word is abandoned. Outputs return to their reset values on the next edge, and no partial byte completes.
- If in_valid and reset are high together, reset wins and no word is accepted.

## Structure
- Shared package convertidor_pkg:
  - Localparams for the PCLK encodings: ANCHO_32 = 2'b00, ANCHO_16 = 2'b01, ANCHO_8 = 2'b10, ANCHO_INV = 2'b11.
  - Function bytes_activos(modo, pclk, nbytes), returning the active count, with 0 meaning invalid.
- Byte select is a plain indexed part-select (word_q[8*idx +: 8]). No sub-module is warranted. Implementation is a single module of about 150 lines.

## Test plan
- IN_W=32, MODO=1, word 0xA1B2C3D4, out_ready=1: out_8 = A1, B2, C3, D4 on cycles N+1..N+4. out_last is high only with D4. in_ready is low on N+1..N+3.
- MODO=0, PCLK=01, word 0x1234ABCD: emits AB, CD. With PCLK=10 and the same word: emits CD alone, with out_last=1.
- MODO=0, PCLK=11, word 0xDEADBEEF: err_modo high for 1 cycle, out_valid stays 0, in_ready stays 1.
- Backpressure: out_ready low for 3 cycles while B2 is presented. B2 and out_last=0 hold; C3 follows on the cycle after out_ready returns high.
- Back-to-back: words 0x01020304 and 0x05060708 with in_valid continuous. Eight consecutive valid bytes 01..08 with no bubble; the second word is accepted on the cycle 04 transfers.
- Reset asserted while C3 is presented: next cycle out_valid=0, out_8=00, in_ready=1. A following word 0x11223344 emits 11 first.
